breadboard_sweeper: RTL and testbench
=====================================

// Module: breadboard_sweeper
// PURPOSE
//  Upstream driver and response capture for the 4-input combinational logic board.
//  On start, it steps the board inputs {w,x,y,z} through all 2**N_IN codes, 0 to 15.
//  For each code it waits SETTLE cycles, samples the function outputs f0..f9 and
//  presents one truth-table row on a valid/ready stream to the display/checker stage.
// PARAMETERS
//  N_IN    4   number of board inputs; a sweep has 2**N_IN rows
//  N_OUT   10  number of board function outputs sampled per row
//  SETTLE  3   cycles each code is held before sampling; legal range >= 1
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      begin a sweep; honoured only in IDLE
//  vec_out    out  N_IN   board inputs; bit N_IN-1 = w (MSB), bit 0 = z
//  f_in       in   N_OUT  board outputs; f_in[k] = fk
//  row_valid  out  1      row_index/row_data hold a captured row
//  row_ready  in   1      consumer accepts the row when row_valid=1
//  row_index  out  N_IN   code that produced row_data
//  row_data   out  N_OUT  sampled f_in for row_index
//  busy       out  1      1 in any state except IDLE
//  done       out  1      one-cycle pulse after the last row is accepted
// BEHAVIOUR
//  Reset (edge with rst=1): state=IDLE; vec_out, row_valid, row_index, row_data, done and
//   the settle counter all go to 0. rst has priority over every other input and aborts
//   a sweep in progress; no done pulse is generated.
//  FSM states: IDLE, DRIVE, WAIT.
//  IDLE
//   - start=1: vec_out<=0, cnt<=0, next state DRIVE.
//   - start=0: remain in IDLE; vec_out holds 0.
//  DRIVE
//   - cnt increments each cycle while cnt != SETTLE-1.
//   - On the edge with cnt==SETTLE-1: row_data<=f_in, row_index<=vec_out,
//     row_valid<=1, next state WAIT.
//   - Result: a code is held exactly SETTLE cycles before it is sampled.
//  WAIT
//   - While row_ready=0: row_valid, row_index, row_data and vec_out hold stable.
//   - f_in changes in WAIT have no effect on the captured row.
//   - Handshake edge (row_valid & row_ready) with vec_out != 2**N_IN-1:
//     row_valid<=0, vec_out<=vec_out+1, cnt<=0, next state DRIVE.
//   - Handshake edge with vec_out == 2**N_IN-1: row_valid<=0, vec_out<=0, done<=1,
//     next state IDLE. The code counter never wraps within a sweep.
//  done
//   - High for exactly one cycle; it coincides with the first cycle of IDLE.
//   - start in that cycle is accepted and begins a new sweep.
//  Ignored inputs: start while busy=1; row_ready while row_valid=0.
//  Latency
//   - Start accepted at edge k: row 0 valid after edge k+SETTLE.
//   - With row_ready held at 1, each row takes SETTLE+1 cycles.
//   - A full sweep takes 16*(SETTLE+1) cycles from the start edge to done.
//  Widths
//   - cnt is $clog2(SETTLE)+1 bits.
//   - vec_out arithmetic is N_IN-bit unsigned.
// TESTING
//  T1 reset: hold rst 2 cycles with random start/row_ready
//     -> all outputs 0, busy=0, no row_valid.
//  T2 full sweep: SETTLE=3, row_ready=1, model f_in = {6'b0,vec_out}
//     -> 16 rows with row_index 0..15 and row_data[3:0]=row_index;
//     -> first row_valid 3 cycles after the start edge;
//     -> exactly one done pulse 64 cycles after start; busy=0 afterwards.
//  T3 backpressure: drop row_ready for 5 cycles on row 2 and toggle f_in meanwhile
//     -> row_index=2, row_data unchanged, vec_out=2 throughout;
//     -> row 3 begins the cycle after row_ready returns.
//  T4 start handling: pulse start at row 5 mid-sweep -> sweep unaffected;
//     assert start in the done cycle -> vec_out=0 and a new sweep starts at row 0.
//  T5 reset mid-operation: assert rst while row 7 is in WAIT
//     -> next cycle all outputs 0 in IDLE, no done pulse;
//     -> a later start restarts at row 0.
//  T6 SETTLE=1 and row_ready=1 -> each row takes 2 cycles; full sweep takes 32 cycles.

Source files
------------

// File: rtl/breadboard_sweeper_if.sv
// rtl/breadboard_sweeper_if.sv - truth-table row stream between the sweeper and the display/checker stage
interface breadboard_sweeper_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 10
);
  logic             row_valid;
  logic             row_ready;
  logic [N_IN-1:0]  row_index;
  logic [N_OUT-1:0] row_data;

  modport master (output row_valid, output row_index, output row_data, input row_ready);
  modport slave  (input row_valid, input row_index, input row_data, output row_ready);
endinterface

// File: rtl/breadboard_sweeper.sv
// rtl/breadboard_sweeper.sv - steps the logic board through every input code and streams one sampled row per code
module breadboard_sweeper #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 10,
  parameter int SETTLE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [N_IN-1:0]       vec_out,
  input  logic [N_OUT-1:0]      f_in,
  breadboard_sweeper_if.master  row,
  output logic                  busy,
  output logic                  done
);
  localparam int              CW       = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [N_IN-1:0]  vec_nx;
  logic             valid_nx;
  logic [N_IN-1:0]  index_nx;
  logic [N_OUT-1:0] data_nx;
  logic             done_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      vec_out       <= '0;
      cnt           <= '0;
      row.row_valid <= 1'b0;
      row.row_index <= '0;
      row.row_data  <= '0;
      done          <= 1'b0;
    end else begin
      state         <= state_nx;
      vec_out       <= vec_nx;
      cnt           <= cnt_nx;
      row.row_valid <= valid_nx;
      row.row_index <= index_nx;
      row.row_data  <= data_nx;
      done          <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    vec_nx   = vec_out;
    cnt_nx   = cnt;
    valid_nx = row.row_valid;
    index_nx = row.row_index;
    data_nx  = row.row_data;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          vec_nx   = '0;
          cnt_nx   = '0;
          state_nx = S_DRIVE;
        end
      end
      S_DRIVE: begin
        // The code has now been on the board for SETTLE cycles; capture it.
        if (cnt == CNT_LAST) begin
          data_nx  = f_in;
          index_nx = vec_out;
          valid_nx = 1'b1;
          state_nx = S_WAIT;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_WAIT: begin
        // row_valid is always 1 here, so row_ready alone completes the handshake.
        if (row.row_ready) begin
          valid_nx = 1'b0;
          if (vec_out == VEC_LAST) begin
            vec_nx   = '0;
            done_nx  = 1'b1;
            state_nx = S_IDLE;
          end else begin
            vec_nx   = vec_out + 1'b1;
            cnt_nx   = '0;
            state_nx = S_DRIVE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
endmodule

// File: tb/tb_breadboard_sweeper.sv
// tb/tb_breadboard_sweeper.sv - directed bench for breadboard_sweeper with SETTLE=3 and SETTLE=1 instances
module tb_breadboard_sweeper;
  logic       clk;
  logic       rst;
  logic       start, start1;
  logic [3:0] vec0, vec1;
  logic [9:0] f0, f1;
  logic       f_sel;
  logic [9:0] f_pat;
  logic       busy0, done0, busy1, done1;
  int         checks, errors;

  breadboard_sweeper_if #(.N_IN(4), .N_OUT(10)) rif0 ();
  breadboard_sweeper_if #(.N_IN(4), .N_OUT(10)) rif1 ();

  assign f0 = f_sel ? f_pat : {6'b0, vec0};
  assign f1 = {6'b0, vec1};

  breadboard_sweeper #(.N_IN(4), .N_OUT(10), .SETTLE(3)) dut0 (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec0), .f_in(f0),
    .row(rif0.master), .busy(busy0), .done(done0)
  );

  breadboard_sweeper #(.N_IN(4), .N_OUT(10), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec_out(vec1), .f_in(f1),
    .row(rif1.master), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'($urandom);
    rif0.row_ready = 1'($urandom);
    tick();
    start = 1'($urandom);
    rif0.row_ready = 1'($urandom);
    tick();
    checks++; if (vec0 !== 4'd0) begin errors++; $display("FAIL reset_vec got %0d exp 0", vec0); end
    checks++; if (rif0.row_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rif0.row_valid); end
    checks++; if (rif0.row_index !== 4'd0) begin errors++; $display("FAIL reset_index got %0d exp 0", rif0.row_index); end
    checks++; if (rif0.row_data !== 10'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", rif0.row_data); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
    rst = 1'b0;
    start = 1'b0;
    rif0.row_ready = 1'b0;
    tick();
  endtask

  task automatic test_full_sweep();
    int rows, dones;
    logic       ev;
    logic [3:0] evec;
    rows = 0;
    dones = 0;
    rif0.row_ready = 1'b1;
    kick();
    for (int c = 1; c <= 66; c++) begin
      tick();
      ev   = (c % 4 == 3) && (c <= 63);
      evec = (c < 64) ? 4'(c / 4) : 4'd0;
      checks++; if (rif0.row_valid !== ev) begin errors++; $display("FAIL sweep_valid c=%0d got %b exp %b", c, rif0.row_valid, ev); end
      checks++; if (vec0 !== evec) begin errors++; $display("FAIL sweep_vec c=%0d got %0d exp %0d", c, vec0, evec); end
      checks++; if (busy0 !== (c < 64)) begin errors++; $display("FAIL sweep_busy c=%0d got %b exp %b", c, busy0, (c < 64)); end
      checks++; if (done0 !== (c == 64)) begin errors++; $display("FAIL sweep_done c=%0d got %b exp %b", c, done0, (c == 64)); end
      if (rif0.row_valid === 1'b1) begin
        rows++;
        checks++; if (rif0.row_index !== 4'(c / 4)) begin errors++; $display("FAIL sweep_index c=%0d got %0d exp %0d", c, rif0.row_index, c / 4); end
        checks++; if (rif0.row_data !== {6'b0, 4'(c / 4)}) begin errors++; $display("FAIL sweep_data c=%0d got %0d exp %0d", c, rif0.row_data, c / 4); end
      end
      if (done0 === 1'b1) dones++;
    end
    checks++; if (rows !== 16) begin errors++; $display("FAIL sweep_rows got %0d exp 16", rows); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL sweep_dones got %0d exp 1", dones); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rif0.row_ready = 1'b1;
    kick();
    for (int c = 1; c <= 10; c++) tick();
    rif0.row_ready = 1'b0;
    tick();
    checks++; if (rif0.row_valid !== 1'b1 || rif0.row_index !== 4'd2) begin errors++; $display("FAIL bp_capture valid=%b index=%0d exp 1/2", rif0.row_valid, rif0.row_index); end
    f_sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f_pat = 10'($urandom) | 10'h200;
      tick();
      checks++; if (rif0.row_valid !== 1'b1) begin errors++; $display("FAIL bp_valid i=%0d got %b exp 1", i, rif0.row_valid); end
      checks++; if (rif0.row_index !== 4'd2) begin errors++; $display("FAIL bp_index i=%0d got %0d exp 2", i, rif0.row_index); end
      checks++; if (rif0.row_data !== 10'd2) begin errors++; $display("FAIL bp_data i=%0d got %0d exp 2", i, rif0.row_data); end
      checks++; if (vec0 !== 4'd2) begin errors++; $display("FAIL bp_vec i=%0d got %0d exp 2", i, vec0); end
    end
    f_sel = 1'b0;
    rif0.row_ready = 1'b1;
    tick();
    checks++; if (vec0 !== 4'd3 || rif0.row_valid !== 1'b0) begin errors++; $display("FAIL bp_release vec=%0d valid=%b exp 3/0", vec0, rif0.row_valid); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (rif0.row_valid !== 1'b1 || rif0.row_index !== 4'd3 || rif0.row_data !== 10'd3) begin errors++; $display("FAIL bp_row3 valid=%b index=%0d data=%0d exp 1/3/3", rif0.row_valid, rif0.row_index, rif0.row_data); end
  endtask

  task automatic test_start_handling();
    int dones;
    dones = 0;
    do_reset();
    rif0.row_ready = 1'b1;
    kick();
    for (int c = 1; c <= 64; c++) begin
      start = (c == 21);
      tick();
      if (done0 === 1'b1) dones++;
      if (c == 23) begin
        checks++; if (rif0.row_valid !== 1'b1 || rif0.row_index !== 4'd5) begin errors++; $display("FAIL st_row5 valid=%b index=%0d exp 1/5", rif0.row_valid, rif0.row_index); end
      end
    end
    checks++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL st_done done=%b busy=%b exp 1/0", done0, busy0); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL st_dones got %0d exp 1", dones); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy0 !== 1'b1 || vec0 !== 4'd0 || done0 !== 1'b0) begin errors++; $display("FAIL st_restart busy=%b vec=%0d done=%b exp 1/0/0", busy0, vec0, done0); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (rif0.row_valid !== 1'b1 || rif0.row_index !== 4'd0) begin errors++; $display("FAIL st_row0 valid=%b index=%0d exp 1/0", rif0.row_valid, rif0.row_index); end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    do_reset();
    rif0.row_ready = 1'b1;
    kick();
    for (int c = 1; c <= 30; c++) tick();
    rif0.row_ready = 1'b0;
    tick();
    tick();
    checks++; if (rif0.row_valid !== 1'b1 || rif0.row_index !== 4'd7) begin errors++; $display("FAIL rm_row7 valid=%b index=%0d exp 1/7", rif0.row_valid, rif0.row_index); end
    rif0.row_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy0 !== 1'b0 || rif0.row_valid !== 1'b0 || vec0 !== 4'd0) begin errors++; $display("FAIL rm_state busy=%b valid=%b vec=%0d exp 0/0/0", busy0, rif0.row_valid, vec0); end
    checks++; if (rif0.row_index !== 4'd0 || rif0.row_data !== 10'd0 || done0 !== 1'b0) begin errors++; $display("FAIL rm_regs index=%0d data=%0d done=%b exp 0/0/0", rif0.row_index, rif0.row_data, done0); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done0 === 1'b1 || busy0 === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rm_quiet got %0d active cycles exp 0", dones); end
    kick();
    for (int i = 0; i < 3; i++) tick();
    checks++; if (rif0.row_valid !== 1'b1 || rif0.row_index !== 4'd0 || rif0.row_data !== 10'd0) begin errors++; $display("FAIL rm_row0 valid=%b index=%0d data=%0d exp 1/0/0", rif0.row_valid, rif0.row_index, rif0.row_data); end
  endtask

  task automatic test_settle1();
    int rows, dones;
    logic ev;
    rows = 0;
    dones = 0;
    rif1.row_ready = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      tick();
      ev = (c % 2 == 1) && (c <= 31);
      checks++; if (rif1.row_valid !== ev) begin errors++; $display("FAIL s1_valid c=%0d got %b exp %b", c, rif1.row_valid, ev); end
      checks++; if (done1 !== (c == 32)) begin errors++; $display("FAIL s1_done c=%0d got %b exp %b", c, done1, (c == 32)); end
      if (rif1.row_valid === 1'b1) begin
        rows++;
        checks++; if (rif1.row_index !== 4'(c / 2) || rif1.row_data !== {6'b0, 4'(c / 2)}) begin errors++; $display("FAIL s1_row c=%0d index=%0d data=%0d exp %0d", c, rif1.row_index, rif1.row_data, c / 2); end
      end
      if (done1 === 1'b1) dones++;
    end
    checks++; if (rows !== 16 || dones !== 1) begin errors++; $display("FAIL s1_totals rows=%0d dones=%0d exp 16/1", rows, dones); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL s1_busy got %b exp 0", busy1); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    f_sel = 1'b0;
    f_pat = 10'd0;
    rif0.row_ready = 1'b0;
    rif1.row_ready = 1'b0;
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_start_handling();
    test_reset_mid();
    test_settle1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
